// File: rtl/clk_rst_seq_if.sv
// Control/status bundle for the staged-reset and clock-enable sequencer.
interface clk_rst_seq_if #(
    parameter int N_STAGE = 3,
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 4
);
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   hold_cycles;
    logic [DIV_W-1:0]   div;
    logic [N_STAGE-1:0] rst_out;
    logic               ce;
    logic               busy;
    logic               running;
    logic               done;

    modport master (
        output start, stop, hold_cycles, div,
        input  rst_out, ce, busy, running, done
    );

    modport slave (
        input  start, stop, hold_cycles, div,
        output rst_out, ce, busy, running, done
    );
endinterface

// File: rtl/clk_rst_seq.sv
// Staged reset release/re-assert sequencer with a programmable-rate clock enable.
// All outputs come straight from flops updated on the rising edge of clk.
module clk_rst_seq #(
    parameter int N_STAGE = 3,
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    clk_rst_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RELEASE, RUN, DRAIN} state_t;

    localparam logic [N_STAGE-1:0] ALL_ONES = {N_STAGE{1'b1}};

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [CNT_W-1:0]   h_reg, h_next;
    logic [DIV_W-1:0]   d_reg, d_next;
    logic [N_STAGE-1:0] rst_out_reg, rst_out_next;
    logic               ce_reg, ce_next;
    logic               busy_reg, busy_next;
    logic               running_reg, running_next;
    logic               done_reg, done_next;

    // Resets form a thermometer code: release shifts a zero in from bit 0,
    // drain shifts a one in from the top.
    logic [N_STAGE-1:0] rel_shift, drn_shift;

    generate
        for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_shift
            if (gi == 0) begin : g_rel_lo
                assign rel_shift[gi] = 1'b0;
            end else begin : g_rel_hi
                assign rel_shift[gi] = rst_out_reg[gi-1];
            end
            if (gi == N_STAGE - 1) begin : g_drn_top
                assign drn_shift[gi] = 1'b1;
            end else begin : g_drn_low
                assign drn_shift[gi] = rst_out_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            div_cnt_reg  <= '0;
            h_reg        <= '0;
            d_reg        <= '0;
            rst_out_reg  <= ALL_ONES;
            ce_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            div_cnt_reg  <= div_cnt_next;
            h_reg        <= h_next;
            d_reg        <= d_next;
            rst_out_reg  <= rst_out_next;
            ce_reg       <= ce_next;
            busy_reg     <= busy_next;
            running_reg  <= running_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        div_cnt_next  = div_cnt_reg;
        h_next        = h_reg;
        d_next        = d_reg;
        rst_out_next  = rst_out_reg;
        ce_next       = 1'b0;
        done_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    h_next        = bus.hold_cycles;
                    d_next        = bus.div;
                    hold_cnt_next = '0;
                    state_next    = RELEASE;
                end
            end
            RELEASE: begin
                if (bus.stop) begin
                    rst_out_next  = ALL_ONES;
                    hold_cnt_next = '0;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end else if (hold_cnt_reg == h_reg) begin
                    rst_out_next  = rel_shift;
                    hold_cnt_next = '0;
                    if (rel_shift == '0) begin
                        div_cnt_next = '0;
                        ce_next      = 1'b1;
                        state_next   = RUN;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    hold_cnt_next = '0;
                    state_next    = DRAIN;
                end else begin
                    // ce for the next cycle fires exactly when the divider wraps.
                    div_cnt_next = (div_cnt_reg == d_reg) ? '0 : div_cnt_reg + 1'b1;
                    ce_next      = (div_cnt_reg == d_reg);
                end
            end
            DRAIN: begin
                if (hold_cnt_reg == h_reg) begin
                    rst_out_next  = drn_shift;
                    hold_cnt_next = '0;
                    if (drn_shift == ALL_ONES) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next    = (state_next != IDLE);
        running_next = (state_next == RUN);
    end

    assign bus.rst_out = rst_out_reg;
    assign bus.ce      = ce_reg;
    assign bus.busy    = busy_reg;
    assign bus.running = running_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench: expected output vectors are derived from the edge-timing
// formulas and queued as stimulus is issued, then popped one per clock edge.
module tb_clk_rst_seq;
    localparam int N_STAGE = 3;
    localparam int CNT_W   = 8;
    localparam int DIV_W   = 4;
    localparam logic [N_STAGE-1:0] ONES = {N_STAGE{1'b1}};

    // {rst_out, ce, busy, running, done}
    typedef logic [N_STAGE+3:0] vec_t;

    logic clk;
    logic rst;
    logic clk_en;
    int   total;
    int   bad;
    int   ce_seen;
    vec_t exp_q[$];

    clk_rst_seq_if #(.N_STAGE(N_STAGE), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

    clk_rst_seq #(.N_STAGE(N_STAGE), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t observed();
        return {bus.rst_out, bus.ce, bus.busy, bus.running, bus.done};
    endfunction

    // Release phase, e = edges since the edge that sampled start.
    function automatic vec_t exp_release(int e, int h, int d);
        int st, dropped;
        logic [N_STAGE-1:0] r;
        logic run, c;
        st      = N_STAGE * (h + 1);
        dropped = e / (h + 1);
        if (dropped > N_STAGE) dropped = N_STAGE;
        r   = ONES << dropped;
        run = (e >= st);
        c   = run && (((e - st) % (d + 1)) == 0);
        return {r, c, 1'b1, run, 1'b0};
    endfunction

    // Shutdown from RUN, e = edges since the edge that sampled stop.
    function automatic vec_t exp_drain(int e, int h);
        int st, raised;
        logic [N_STAGE-1:0] r;
        st     = N_STAGE * (h + 1);
        raised = e / (h + 1);
        if (raised > N_STAGE) raised = N_STAGE;
        r = ONES << (N_STAGE - raised);
        return {r, 1'b0, (e < st), 1'b0, (e == st)};
    endfunction

    task automatic step(input string tag);
        vec_t got, exp;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        got = observed();
        if (exp_q.size() == 0) begin
            check_val({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check_val(tag, 32'(got), 32'(exp));
            $display("t=%0t %s out=%b exp=%b", $time, tag, got, exp);
        end
        if (bus.ce) ce_seen++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk_en = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.hold_cycles = '0;
        bus.div = '0;

        // Reset applied with no clock running
        rst = 1'b1;
        #7;
        check_val("reset_vec", 32'(observed()), 32'({ONES, 4'b0000}));
        rst = 1'b0;
        clk_en = 1'b1;
        #3;

        // Release H=2 D=3, with ignored start and div change during RUN
        bus.hold_cycles = 8'd2;
        bus.div = 4'd3;
        bus.start = 1'b1;
        for (int i = 0; i < 49; i++) exp_q.push_back(exp_release(i, 2, 3));
        ce_seen = 0;
        for (int i = 0; i < 49; i++) begin
            if (i == 20) bus.start = 1'b1;
            if (i == 25) begin bus.div = 4'd0; bus.hold_cycles = 8'd7; end
            if (i == 9) ce_seen = 0;
            step("release");
        end
        check_val("ce_count_40", 32'(ce_seen), 32'd10);

        // Shutdown from RUN
        bus.stop = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_drain(i, 2));
        for (int i = 0; i < 12; i++) step("drain");

        // stop in IDLE is ignored
        bus.stop = 1'b1;
        exp_q.push_back({ONES, 4'b0000});
        step("idle_stop");

        // Abort during RELEASE, H=4
        bus.hold_cycles = 8'd4;
        bus.div = 4'd1;
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_release(i, 4, 1));
        for (int i = 0; i < 6; i++) step("abort_rel");
        bus.stop = 1'b1;
        exp_q.push_back({ONES, 4'b0001});
        exp_q.push_back({ONES, 4'b0000});
        exp_q.push_back({ONES, 4'b0000});
        for (int i = 0; i < 3; i++) step("abort");

        // H=0 D=0, then start+stop together in RUN
        bus.hold_cycles = 8'd0;
        bus.div = 4'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_release(i, 0, 0));
        for (int i = 0; i < 8; i++) step("fast_rel");
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_drain(i, 0));
        for (int i = 0; i < 6; i++) step("both_drain");

        // Async reset mid-RUN, H=1 D=2
        bus.hold_cycles = 8'd1;
        bus.div = 4'd2;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_release(i, 1, 2));
        for (int i = 0; i < 10; i++) step("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst", 32'(observed()), 32'({ONES, 4'b0000}));
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back({ONES, 4'b0000});
        for (int i = 0; i < 3; i++) step("post_rst");
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_release(i, 1, 2));
        for (int i = 0; i < 12; i++) step("rerelease");

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
